// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and phase decode for the VGA timing path.
// The clock divider top level and the pixel source import this too, so they agree on geometry.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // Each phase is a half-open range on the axis position, in order ACTIVE, FRONT, SYNC, BACK.
  function automatic phase_e phase_of(input int unsigned pos, input int unsigned active,
                                      input int unsigned fp, input int unsigned sync);
    phase_e ph;
    if (pos < active)                   ph = PH_ACTIVE;
    else if (pos < active + fp)         ph = PH_FRONT;
    else if (pos < active + fp + sync)  ph = PH_SYNC;
    else                                ph = PH_BACK;
    return ph;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered sync/active/zero flags.
// Flags are decoded from the next position so they line up with the registered count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_sync,
  output logic         o_active,
  output logic         o_zero,
  output logic         o_wrap
);

  localparam int unsigned  TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] MAX   = W'(TOTAL - 1);

  logic [W-1:0] r_count;
  logic         r_sync;
  logic         r_active;
  logic         r_zero;
  logic [W-1:0] w_next;
  phase_e       w_phase;

  always_comb begin
    w_next = r_count;
    if (i_en) begin
      w_next = (r_count == MAX) ? '0 : r_count + 1'b1;
    end
    w_phase = phase_of(32'(w_next), ACTIVE, FP, SYNC);
  end

  assign o_wrap = i_en && (r_count == MAX);

  // Reset parks the axis on its last position so the first enabled edge lands on zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= MAX;
      r_sync   <= 1'b0;
      r_active <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_count  <= w_next;
      r_sync   <= (w_phase == PH_SYNC);
      r_active <= (w_phase == PH_ACTIVE);
      r_zero   <= (w_next == '0);
    end
  end

  assign o_count  = r_count;
  assign o_sync   = r_sync;
  assign o_active = r_active;
  assign o_zero   = r_zero;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters chained on the line wrap.
// Combines the registered axis flags into sync, video_on and the line/frame markers.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10
) (
  input  logic           clk,
  input  logic           rst,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           line_start,
  output logic           frame_start
);

  logic w_h_sync, w_h_active, w_h_zero, w_h_wrap;
  logic w_v_sync, w_v_active, w_v_zero, w_v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (X_W)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (1'b1),
    .o_count  (pixel_x),
    .o_sync   (w_h_sync),
    .o_active (w_h_active),
    .o_zero   (w_h_zero),
    .o_wrap   (w_h_wrap)
  );

  // The vertical axis only steps on the last pixel of a line, so its flags hold for whole lines.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (Y_W)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_h_wrap),
    .o_count  (pixel_y),
    .o_sync   (w_v_sync),
    .o_active (w_v_active),
    .o_zero   (w_v_zero),
    .o_wrap   (w_v_wrap)
  );

  assign hsync       = w_h_sync ? SYNC_POL : ~SYNC_POL;
  assign vsync       = w_v_sync ? SYNC_POL : ~SYNC_POL;
  assign video_on    = w_h_active & w_v_active;
  assign line_start  = w_h_zero;
  assign frame_start = w_h_zero & w_v_zero;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a tiny active-high-sync instance.
// A raster model pushes the expected outputs each clock; each scenario pops and compares them.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
  } exp_t;

  localparam int D_HT = 800, D_VT = 525;
  localparam int S_HT = 15,  S_VT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_von, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_von, s_ls, s_fs;
  logic [3:0] s_x, s_y;

  vga_sync_gen u_dut_d (
    .clk(clk), .rst(rst), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .pixel_x(d_x), .pixel_y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .X_W(4), .Y_W(4)
  ) u_dut_s (
    .clk(clk), .rst(rst), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .pixel_x(s_x), .pixel_y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  exp_t d_act, s_act;
  assign d_act = {d_x, d_y, d_hs, d_vs, d_von, d_ls, d_fs};
  assign s_act = {6'd0, s_x, 6'd0, s_y, s_hs, s_vs, s_von, s_ls, s_fs};

  exp_t qd[$];
  exp_t qs[$];
  int dmx = D_HT - 1, dmy = D_VT - 1, smx = S_HT - 1, smy = S_VT - 1;
  int tests = 0, fails = 0, cyc = 0;

  function automatic exp_t exp_of(input int x, input int y, input int ha, input int hf,
                                  input int hsw, input int va, input int vf, input int vsw,
                                  input bit pol);
    exp_t e;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.hs  = (x >= ha + hf && x < ha + hf + hsw) ? pol : !pol;
    e.vs  = (y >= va + vf && y < va + vf + vsw) ? pol : !pol;
    e.von = (x < ha) && (y < va);
    e.ls  = (x == 0);
    e.fs  = (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic push_exp();
    qd.push_back(exp_of(dmx, dmy, 640, 16, 96, 480, 10, 2, 1'b0));
    qs.push_back(exp_of(smx, smy, 8, 2, 3, 4, 1, 2, 1'b1));
  endtask

  task automatic model_reset();
    dmx = D_HT - 1; dmy = D_VT - 1;
    smx = S_HT - 1; smy = S_VT - 1;
  endtask

  // Advance the model across one rising edge and leave time at edge+1 for sampling.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else begin
      if (dmx == D_HT - 1) begin dmx = 0; dmy = (dmy == D_VT - 1) ? 0 : dmy + 1; end
      else dmx++;
      if (smx == S_HT - 1) begin smx = 0; smy = (smy == S_VT - 1) ? 0 : smy + 1; end
      else smx++;
    end
    push_exp();
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = qd.pop_front(); tests++;
      if (d_act !== e) begin fails++; $display("FAIL reset_hold_d act=%h exp=%h", d_act, e); end
      e = qs.pop_front(); tests++;
      if (s_act !== e) begin fails++; $display("FAIL reset_hold_s act=%h exp=%h", s_act, e); end
    end
    tests++;
    if ({d_x, d_y, d_hs, d_vs, d_von, d_ls, d_fs} !== {10'd799, 10'd524, 1'b1, 1'b1, 3'b000}) begin
      fails++;
      $display("FAIL reset_values x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b exp 799/524/1/1/0/0/0",
               d_x, d_y, d_hs, d_vs, d_von, d_ls, d_fs);
    end
    #2 rst = 1'b0;
    tick();
    e = qd.pop_front(); tests++;
    if (d_act !== e) begin fails++; $display("FAIL release_d act=%h exp=%h", d_act, e); end
    e = qs.pop_front(); tests++;
    if (s_act !== e) begin fails++; $display("FAIL release_s act=%h exp=%h", s_act, e); end
    tests++;
    if ({d_x, d_y, d_von, d_ls, d_fs} !== {20'd0, 3'b111}) begin
      fails++;
      $display("FAIL first_pixel x=%0d y=%0d von=%b ls=%b fs=%b exp 0/0/1/1/1",
               d_x, d_y, d_von, d_ls, d_fs);
    end
  endtask

  task automatic test_h_line();
    exp_t e;
    int n_hs_low = 0, n_von = 0, n_ls = 0;
    for (int i = 0; i < D_HT; i++) begin
      tick();
      e = qd.pop_front(); tests++;
      if (d_act !== e) begin fails++; $display("FAIL hline_d x=%0d act=%h exp=%h", dmx, d_act, e); end
      e = qs.pop_front(); tests++;
      if (s_act !== e) begin fails++; $display("FAIL hline_s act=%h exp=%h", s_act, e); end
      if (d_hs == 1'b0) n_hs_low++;
      if (d_von) n_von++;
      if (d_ls) n_ls++;
    end
    tests++;
    if (n_hs_low != 96) begin fails++; $display("FAIL hsync_width got=%0d exp=96", n_hs_low); end
    tests++;
    if (n_von != 640) begin fails++; $display("FAIL video_on_width got=%0d exp=640", n_von); end
    tests++;
    if (n_ls != 1) begin fails++; $display("FAIL line_start_count got=%0d exp=1", n_ls); end
    tests++;
    if (d_x !== 10'd0 || d_y !== 10'd1) begin
      fails++; $display("FAIL line_wrap x=%0d y=%0d exp 0/1", d_x, d_y);
    end
  endtask

  task automatic test_small_frame();
    exp_t e;
    int n_hs = 0, n_vs = 0, n_von = 0, n_fs = 0, last_fs = -1, max_x = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      e = qd.pop_front(); tests++;
      if (d_act !== e) begin fails++; $display("FAIL frame_d act=%h exp=%h", d_act, e); end
      e = qs.pop_front(); tests++;
      if (s_act !== e) begin fails++; $display("FAIL frame_s x=%0d y=%0d act=%h exp=%h", smx, smy, s_act, e); end
      if (i < 120) begin
        if (s_hs) n_hs++;
        if (s_vs) n_vs++;
        if (s_von) n_von++;
      end
      if (int'(s_x) > max_x) max_x = int'(s_x);
      if (s_fs) begin
        n_fs++;
        if (last_fs >= 0) begin
          tests++;
          if (cyc - last_fs != 120) begin
            fails++; $display("FAIL frame_period got=%0d exp=120", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
    end
    tests++;
    if (n_hs != 24) begin fails++; $display("FAIL small_hsync_high got=%0d exp=24", n_hs); end
    tests++;
    if (n_vs != 30) begin fails++; $display("FAIL small_vsync_high got=%0d exp=30", n_vs); end
    tests++;
    if (n_von != 32) begin fails++; $display("FAIL small_video_on got=%0d exp=32", n_von); end
    tests++;
    if (n_fs < 2) begin fails++; $display("FAIL small_frame_starts got=%0d exp>=2", n_fs); end
    tests++;
    if (max_x > 14) begin fails++; $display("FAIL small_max_x got=%0d exp<=14", max_x); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int guard = 0;
    while (!(dmx == 300 && dmy == 1) && guard < 2000) begin
      tick();
      guard++;
      e = qd.pop_front(); tests++;
      if (d_act !== e) begin fails++; $display("FAIL seek_d act=%h exp=%h", d_act, e); end
      e = qs.pop_front(); tests++;
      if (s_act !== e) begin fails++; $display("FAIL seek_s act=%h exp=%h", s_act, e); end
    end
    tests++;
    if (guard >= 2000) begin fails++; $display("FAIL seek_timeout x=%0d y=%0d exp 300/1", dmx, dmy); end
    #2 rst = 1'b1;
    model_reset();
    push_exp();
    #1;
    e = qd.pop_front(); tests++;
    if (d_act !== e) begin fails++; $display("FAIL async_reset_d act=%h exp=%h", d_act, e); end
    e = qs.pop_front(); tests++;
    if (s_act !== e) begin fails++; $display("FAIL async_reset_s act=%h exp=%h", s_act, e); end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = qd.pop_front(); tests++;
      if (d_act !== e) begin fails++; $display("FAIL reset_hold2_d act=%h exp=%h", d_act, e); end
      e = qs.pop_front(); tests++;
      if (s_act !== e) begin fails++; $display("FAIL reset_hold2_s act=%h exp=%h", s_act, e); end
    end
    #2 rst = 1'b0;
    tick();
    e = qd.pop_front(); tests++;
    if (d_act !== e) begin fails++; $display("FAIL restart_d act=%h exp=%h", d_act, e); end
    e = qs.pop_front(); tests++;
    if (s_act !== e) begin fails++; $display("FAIL restart_s act=%h exp=%h", s_act, e); end
    tests++;
    if ({d_x, d_y, d_fs} !== {20'd0, 1'b1}) begin
      fails++; $display("FAIL restart_origin x=%0d y=%0d fs=%b exp 0/0/1", d_x, d_y, d_fs);
    end
  endtask

  initial begin
    test_reset();
    test_h_line();
    test_small_frame();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
